branch_predict_assoc: RTL and testbench

Parametrised set-associative branch target buffer with a per-entry saturating direction counter; successor to the direct-mapped 2-bit predictor in the fetch stage.
- Lookup is issued with next_pc; the prediction is produced in the following cycle against pc.
- Updates arrive from EX.
- Adds tags, valid bits, configurable ways and sets, allocate-on-taken, per-set round-robin replacement, read enable for fetch stalls, and a one-cycle flush.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predict_assoc.sv | 154 +++++++++++++++
 tb/tb_branch_predict_assoc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the set-associative branch predictor.
// Provides default fetch-stage parameters, counter limits and PC slicing.
package bp_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SETS       = 64;
  localparam int DEF_WAYS       = 4;
  localparam int DEF_CNT_WIDTH  = 2;

  localparam int CNT_MAX    = (1 << DEF_CNT_WIDTH) - 1;
  localparam int CNT_WEAK_T = 1 << (DEF_CNT_WIDTH - 1);

  function automatic int bp_cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int bp_cnt_weak(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic logic [63:0] bp_set(
    input logic [63:0] a,
    input int          idx_w
  );
    return (a >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(
    input logic [63:0] a,
    input int          idx_w
  );
    return a >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next value of a saturating direction counter.
// cnt: current value, taken: outcome, cnt_nxt: saturated +/-1.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 taken,
  output logic [CNT_WIDTH-1:0] cnt_nxt
);

  localparam logic [CNT_WIDTH-1:0] C_MAX =
    CNT_WIDTH'(bp_cnt_max(CNT_WIDTH));

  always_comb begin
    cnt_nxt = cnt;
    if (taken && cnt != C_MAX)
      cnt_nxt = cnt + 1'b1;
    else if (!taken && cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

endmodule

// File: rtl/branch_predict_assoc.sv
// Set-associative BTB with per-entry saturating direction counters.
// Lookup: rd_en/next_pc -> predict_* vs pc next cycle; update: upd_*; flush.
module branch_predict_assoc
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  predict_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target_pc,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  flush
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int PTR_W = $clog2(WAYS);
  localparam logic [CNT_WIDTH-1:0] C_WEAK =
    CNT_WIDTH'(bp_cnt_weak(CNT_WIDTH));

  logic [WAYS-1:0]       vld_q [SETS];
  logic [CNT_WIDTH-1:0]  cnt_q [SETS][WAYS];
  logic [PTR_W-1:0]      ptr_q [SETS];
  logic [TAG_W-1:0]      tag_q [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] tgt_q [SETS][WAYS];

  logic [WAYS-1:0]       r_vld_q;
  logic [TAG_W-1:0]      r_tag_q [WAYS];
  logic [CNT_WIDTH-1:0]  r_cnt_q [WAYS];
  logic [ADDR_WIDTH-1:0] r_tgt_q [WAYS];

  logic [IDX_W-1:0] rd_set, u_set;
  logic [TAG_W-1:0] pc_tag, u_tag;

  assign rd_set = IDX_W'(bp_set(64'(next_pc), IDX_W));
  assign pc_tag = TAG_W'(bp_tag(64'(pc), IDX_W));
  assign u_set  = IDX_W'(bp_set(64'(upd_pc), IDX_W));
  assign u_tag  = TAG_W'(bp_tag(64'(upd_pc), IDX_W));

  logic             hit;
  logic [PTR_W-1:0] sel;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_vld_q[w] && r_tag_q[w] == pc_tag) begin
        hit = 1'b1;
        sel = PTR_W'(w);
      end
    end
  end

  assign predict_hit       = hit;
  assign predict_taken     = hit & r_cnt_q[sel][CNT_WIDTH-1];
  assign predict_target_pc = hit ? r_tgt_q[sel] : '0;

  logic             u_hit, inv_any;
  logic [PTR_W-1:0] u_way, inv_way, victim, wr_way;

  always_comb begin
    u_hit   = 1'b0;
    u_way   = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[u_set][w] && tag_q[u_set][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = PTR_W'(w);
      end
      if (!vld_q[u_set][w]) begin
        inv_any = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
  end

  assign victim = inv_any ? inv_way : ptr_q[u_set];
  assign wr_way = u_hit ? u_way : victim;

  logic                 do_upd, wr_hit, wr_alloc;
  logic [CNT_WIDTH-1:0] u_cnt_d;

  assign do_upd   = upd_valid && !flush;
  assign wr_hit   = do_upd && u_hit;
  assign wr_alloc = do_upd && !u_hit && upd_taken;

  bp_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sat (
    .cnt     (cnt_q[u_set][u_way]),
    .taken   (upd_taken),
    .cnt_nxt (u_cnt_d)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_vld_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_tag_q[w] <= '0;
        r_cnt_q[w] <= '0;
        r_tgt_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          cnt_q[s][w] <= '0;
      end
    end else begin
      if (rd_en) begin
        r_vld_q <= vld_q[rd_set];
        for (int w = 0; w < WAYS; w++) begin
          r_tag_q[w] <= tag_q[rd_set][w];
          r_cnt_q[w] <= cnt_q[rd_set][w];
          r_tgt_q[w] <= tgt_q[rd_set][w];
        end
      end
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          vld_q[s] <= '0;
          ptr_q[s] <= '0;
        end
      end else if (wr_hit) begin
        cnt_q[u_set][u_way] <= u_cnt_d;
      end else if (wr_alloc) begin
        vld_q[u_set][victim] <= 1'b1;
        cnt_q[u_set][victim] <= C_WEAK;
        // pointer only moves when a live entry is evicted
        if (!inv_any)
          ptr_q[u_set] <= ptr_q[u_set] + 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      if (wr_alloc || (wr_hit && upd_taken))
        tgt_q[u_set][wr_way] <= upd_target;
      if (wr_alloc)
        tag_q[u_set][wr_way] <= u_tag;
    end
  end

endmodule

// File: tb/tb_branch_predict_assoc.sv
// Directed table plus randomized checks of branch_predict_assoc
// against a behavioural BTB model.
module tb_branch_predict_assoc;

  localparam int NS = 64;
  localparam int NW = 4;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        rst, rd_en, upd_valid, upd_taken, flush;
  logic [31:0] next_pc, pc, upd_pc, upd_target;
  logic        p_hit, p_taken;
  logic [31:0] p_tgt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predict_assoc dut (
    .cpu_clk           (clk),
    .cpu_rst           (rst),
    .rd_en             (rd_en),
    .next_pc           (next_pc),
    .pc                (pc),
    .predict_hit       (p_hit),
    .predict_taken     (p_taken),
    .predict_target_pc (p_tgt),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .flush             (flush)
  );

  bit          m_v   [NS][NW];
  int unsigned m_tag [NS][NW];
  int unsigned m_tgt [NS][NW];
  int          m_cnt [NS][NW];
  int          m_ptr [NS];
  bit          r_v   [NW];
  int unsigned r_tag [NW];
  int unsigned r_tgt [NW];
  int          r_cnt [NW];

  function automatic int sidx(input int unsigned a);
    return int'((a / 4) % NS);
  endfunction

  function automatic int unsigned stag(input int unsigned a);
    return a / (4 * NS);
  endfunction

  function automatic void model_step();
    int s, hw, vw;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_ptr[i] = 0;
        for (int w = 0; w < NW; w++) begin
          m_v[i][w] = 0;
          m_cnt[i][w] = 0;
        end
      end
      for (int w = 0; w < NW; w++) begin
        r_v[w] = 0; r_tag[w] = 0;
        r_tgt[w] = 0; r_cnt[w] = 0;
      end
      return;
    end
    if (rd_en) begin
      s = sidx(next_pc);
      for (int w = 0; w < NW; w++) begin
        r_v[w]   = m_v[s][w];
        r_tag[w] = m_tag[s][w];
        r_tgt[w] = m_tgt[s][w];
        r_cnt[w] = m_cnt[s][w];
      end
    end
    if (flush) begin
      for (int i = 0; i < NS; i++) begin
        m_ptr[i] = 0;
        for (int w = 0; w < NW; w++) m_v[i][w] = 0;
      end
      return;
    end
    if (!upd_valid) return;
    s = sidx(upd_pc);
    hw = -1;
    for (int w = 0; w < NW; w++)
      if (hw < 0 && m_v[s][w] && m_tag[s][w] == stag(upd_pc))
        hw = w;
    if (hw >= 0) begin
      if (upd_taken) begin
        if (m_cnt[s][hw] < CMAX) m_cnt[s][hw]++;
        m_tgt[s][hw] = upd_target;
      end else if (m_cnt[s][hw] > 0) begin
        m_cnt[s][hw]--;
      end
    end else if (upd_taken) begin
      vw = -1;
      for (int w = 0; w < NW; w++)
        if (vw < 0 && !m_v[s][w]) vw = w;
      if (vw < 0) begin
        vw = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % NW;
      end
      m_v[s][vw]   = 1;
      m_tag[s][vw] = stag(upd_pc);
      m_tgt[s][vw] = upd_target;
      m_cnt[s][vw] = (CMAX + 1) / 2;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(
    input string       nm,
    input bit          eh,
    input bit          et,
    input int unsigned eg
  );
    n_tests++;
    if (p_hit !== eh || p_taken !== et || p_tgt !== eg) begin
      n_fail++;
      $display("FAIL %s: got hit=%0b tk=%0b tgt=%h want %0b %0b %h",
               nm, p_hit, p_taken, p_tgt, eh, et, eg);
    end
  endtask

  typedef struct {
    bit          rst, rd, uv, ut, fl, eh, et;
    int unsigned npc, p, upc, utg, etg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
    bit rs, bit rd, int unsigned npc, int unsigned p,
    bit uv, int unsigned upc, bit ut, int unsigned utg,
    bit fl, bit eh, bit et, int unsigned etg);
    vec_t v;
    v.rst = rs; v.rd = rd; v.npc = npc; v.p = p;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.fl = fl; v.eh = eh; v.et = et; v.etg = etg;
    return v;
  endfunction

  function automatic vec_t L(int unsigned a, bit eh, bit et,
                             int unsigned etg);
    return V(0, 1, a, a, 0, 0, 0, 0, 0, eh, et, etg);
  endfunction

  function automatic vec_t U(int unsigned a, bit t, int unsigned g);
    return V(0, 1, 32'h1004, 32'h1004, 1, a, t, g, 0, 0, 0, 0);
  endfunction

  function automatic int unsigned raddr();
    int unsigned t, s;
    t = $urandom_range(0, 7);
    s = $urandom_range(0, 2);
    return (t << 8) | (s << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1; rd_en = 0; next_pc = 0; pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; flush = 0;

    tbl.push_back(V(1, 1, 'h100, 'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 1, 'h100, 'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(L('h100, 0, 0, 0));
    tbl.push_back(U('h100, 1, 'h200));
    tbl.push_back(L('h100, 1, 1, 'h200));
    tbl.push_back(U('h100, 1, 'h200));
    tbl.push_back(U('h100, 1, 'h200));
    tbl.push_back(U('h100, 1, 'h200));
    tbl.push_back(U('h100, 0, 0));
    tbl.push_back(L('h100, 1, 1, 'h200));
    tbl.push_back(U('h100, 0, 0));
    tbl.push_back(L('h100, 1, 0, 'h200));
    tbl.push_back(U('h200, 1, 'h2200));
    tbl.push_back(U('h300, 1, 'h3300));
    tbl.push_back(U('h400, 1, 'h4400));
    tbl.push_back(U('h500, 1, 'h5500));
    tbl.push_back(L('h100, 0, 0, 0));
    tbl.push_back(L('h500, 1, 1, 'h5500));
    tbl.push_back(L('h200, 1, 1, 'h2200));
    tbl.push_back(V(0, 1, 'h600, 'h600, 1, 'h600, 1, 'h6600,
                    0, 0, 0, 0));
    tbl.push_back(L('h600, 1, 1, 'h6600));
    tbl.push_back(L('h200, 0, 0, 0));
    tbl.push_back(L('h300, 1, 1, 'h3300));
    tbl.push_back(U('h700, 0, 'h7700));
    tbl.push_back(L('h700, 0, 0, 0));
    tbl.push_back(V(0, 1, 'h1004, 'h1004, 1, 'h800, 1, 'h8800,
                    1, 0, 0, 0));
    tbl.push_back(L('h800, 0, 0, 0));
    tbl.push_back(L('h600, 0, 0, 0));
    tbl.push_back(L('h500, 0, 0, 0));
    tbl.push_back(U('h900, 1, 'h9900));
    tbl.push_back(L('h900, 1, 1, 'h9900));
    tbl.push_back(V(0, 0, 'h100, 'h900, 0, 0, 0, 0, 0, 1, 1, 'h9900));
    tbl.push_back(V(0, 0, 'h100, 'h900, 1, 'h900, 0, 0,
                    0, 1, 1, 'h9900));
    tbl.push_back(V(0, 0, 'h900, 'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(L('h900, 1, 0, 'h9900));
    tbl.push_back(V(0, 0, 'h900, 'h900, 0, 0, 0, 0, 1, 1, 0, 'h9900));
    tbl.push_back(L('h900, 0, 0, 0));
    tbl.push_back(U('hA00, 1, 'hAA00));
    tbl.push_back(V(1, 1, 'hA00, 'hA00, 1, 'hA00, 1, 'hAA00,
                    1, 0, 0, 0));
    tbl.push_back(L('hA00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      rd_en      = tbl[i].rd;
      next_pc    = tbl[i].npc;
      pc         = tbl[i].p;
      upd_valid  = tbl[i].uv;
      upd_pc     = tbl[i].upc;
      upd_taken  = tbl[i].ut;
      upd_target = tbl[i].utg;
      flush      = tbl[i].fl;
      tick();
      check($sformatf("vec%0d", i), tbl[i].eh, tbl[i].et,
            tbl[i].etg);
    end

    // saturation: one not-taken after saturating must still predict taken
    rst = 0; flush = 0; rd_en = 1;
    next_pc = 'h1004; pc = 'h1004;
    upd_valid = 1; upd_pc = 'h104; upd_taken = 1; upd_target = 'h40;
    for (int k = 0; k < 4; k++) tick();
    upd_taken = 0;
    tick();
    upd_valid = 0; next_pc = 'h104; pc = 'h104;
    tick();
    check("sat_hold", 1, 1, 'h40);

    rst = 1; upd_valid = 0; flush = 0;
    tick(); tick();
    rst = 0;

    for (int c = 0; c < 4000; c++) begin
      int unsigned a;
      a = raddr();
      pc        = ($urandom_range(0, 3) == 0) ? raddr() : next_pc;
      next_pc   = a;
      rd_en     = ($urandom_range(0, 4) != 0);
      upd_valid = ($urandom_range(0, 1) == 1);
      upd_pc    = raddr();
      upd_taken = ($urandom_range(0, 9) < 6);
      upd_target = $urandom;
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
      begin
        bit eh, et;
        int unsigned eg;
        eh = 0; et = 0; eg = 0;
        for (int w = 0; w < NW; w++) begin
          if (!eh && r_v[w] && r_tag[w] == stag(pc)) begin
            eh = 1;
            et = (r_cnt[w] >= (CMAX + 1) / 2);
            eg = r_tgt[w];
          end
        end
        check($sformatf("rnd%0d", c), eh, et, eg);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
